// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer.
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_mem_ctrl).
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size in bytes (1, 2 or 4) from funct3[1:0].
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: store mask/shift and load shift/extend.
// One shifter path per direction replaces per-offset byte selection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        split,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_buf,
  input  logic [31:0] rdata,
  output logic [7:0]  mask8,
  output logic [63:0] sdata64,
  output logic [31:0] ldata
);

  logic [4:0]  sh_amt;
  logic [3:0]  size_mask;
  logic [31:0] wmasked;
  logic [63:0] word64;
  logic [63:0] shifted;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sh_amt    = {off, 3'b000};
    size_mask = 4'b1111;
    wmasked   = wdata;
    case (funct3[1:0])
      2'b00: begin
        size_mask = 4'b0001;
        wmasked   = {24'b0, wdata[7:0]};
      end
      2'b01: begin
        size_mask = 4'b0011;
        wmasked   = {16'b0, wdata[15:0]};
      end
      default: ;
    endcase

    mask8   = {4'b0000, size_mask} << off;
    sdata64 = {32'b0, wmasked} << sh_amt;

    word64  = split ? {rdata, lo_buf} : {32'b0, rdata};
    shifted = word64 >> sh_amt;

    case (funct3)
      F3_LB:   ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ldata = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ldata = {24'b0, shifted[7:0]};
      F3_LHU:  ldata = {16'b0, shifted[15:0]};
      default: ldata = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between MEM stage and word-organised synchronous RAM.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t state, state_next;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_buf;

  logic [1:0]        off;
  logic [3:0]        end_byte;
  logic              split;
  logic [RAM_AW-1:0] word_addr;
  logic [7:0]        mask8;
  logic [63:0]       sdata64;
  logic [31:0]       ldata;

  assign off       = addr_q[1:0];
  assign end_byte  = {2'b00, off} + {1'b0, size_of(f3_q)};
  assign split     = end_byte > 4'd4;
  assign word_addr = addr_q[RAM_AW+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_req;
  always_comb begin
    misaligned_req = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned_req = req_addr[0];
      2'b10:   misaligned_req = |req_addr[1:0];
      default: misaligned_req = 1'b0;
    endcase
  end
`endif

  lsu_align u_align (
    .funct3  (f3_q),
    .off     (off),
    .split   (split),
    .wdata   (wdata_q),
    .lo_buf  (lo_buf),
    .rdata   (ram_rdata),
    .mask8   (mask8),
    .sdata64 (sdata64),
    .ldata   (ldata)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      lo_buf  <= 32'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == S_HI) lo_buf <= ram_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_legal(req_we, req_funct3)) state_next = S_ERR;
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misaligned_req)          state_next = S_ERR;
`endif
          else                              state_next = S_LO;
        end
      end
      S_LO:    state_next = split ? S_HI : S_DONE;
      S_HI:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // RAM drive is decoded from state alone, so reset drops an access immediately.
  always_comb begin
    req_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'b0;
    ram_en     = 1'b0;
    ram_addr   = word_addr;
    ram_be     = 4'b0000;
    ram_wdata  = sdata64[31:0];
    case (state)
      S_LO: begin
        ram_en = 1'b1;
        ram_be = we_q ? mask8[3:0] : 4'b0000;
      end
      S_HI: begin
        ram_en    = 1'b1;
        ram_addr  = word_addr + RAM_AW'(1);
        ram_be    = we_q ? mask8[7:4] : 4'b0000;
        ram_wdata = sdata64[63:32];
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? 32'b0 : ldata;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
